fft_frame_ctrl: RTL
===================

// Module: fft_frame_ctrl
// PURPOSE
// - Sequences the xfft_1 FFT core. Captures 8-bit audio samples into ping-pong frame banks.
// - Sends a one-shot config word, then streams each full frame to the core's s_axis_data port with tlast.
// - Indexes the core's m_axis output bins for the downstream spectrum consumer.
// - Sits between the audio sampler and the FFT/display path.
// PARAMETERS
// - FRAME_LEN  2048      samples per frame / bins per output frame (power of 2, >=8)
// - SAMPLE_W   8         audio sample width
// - CFG_WORD   16'h0001  word sent on s_axis_config after reset (bit0=1: forward FFT)
// PORTS
// - clk_in              in   1   system clock (100 MHz)
// - rst_in              in   1   asynchronous, active-high reset
// - audio_in            in   8   audio sample, captured when audio_valid_in=1
// - audio_valid_in      in   1   single-cycle sample strobe; no backpressure toward the source
// - cfg_tdata           out  16  to core s_axis_config_tdata
// - cfg_tvalid          out  1   to core s_axis_config_tvalid
// - cfg_tready          in   1   from core s_axis_config_tready
// - fft_tdata           out  32  to core s_axis_data_tdata: {16'h0000 imag, audio,8'h00 real}
// - fft_tvalid          out  1   to core s_axis_data_tvalid
// - fft_tlast           out  1   to core s_axis_data_tlast; high on sample FRAME_LEN-1
// - fft_tready          in   1   from core s_axis_data_tready
// - fft_out_tdata       in   32  from core m_axis_data_tdata {im[31:16], re[15:0]}
// - fft_out_tvalid      in   1   from core m_axis_data_tvalid
// - fft_out_tlast       in   1   from core m_axis_data_tlast
// - fft_out_tready      out  1   to core m_axis_data_tready
// - bin_data            out  32  bin value to consumer
// - bin_idx             out  $clog2(FRAME_LEN)  bin index of bin_data
// - bin_valid / bin_last  out 1  bin handshake valid / last bin of frame
// - bin_ready           in   1   consumer ready
// - frame_cnt           out  16  frames handed to core (wraps at 16'hFFFF->0)
// - overrun / tlast_err out  1   sticky flags, cleared only by reset
// BEHAVIOUR
// - Reset values:
//   - All valids, tlast, flags, frame_cnt and bin_idx are 0.
//   - cfg_tdata=CFG_WORD. Capture bank=0, both banks empty.
//   - Reset mid-frame discards all buffered and partial data.
// - Tx FSM: CFG -> WAIT -> STREAM -> WAIT.
//   - CFG: cfg_tvalid=1 from the first cycle after reset until cfg_tvalid&cfg_tready, then WAIT; config is sent exactly once.
//   - WAIT: when a full bank is pending, go to STREAM.
//   - STREAM: sample k (0..FRAME_LEN-1) is presented; advance on fft_tvalid&fft_tready; tdata/tvalid held stable while stalled.
//   - After the tlast handshake: release the bank, frame_cnt+1, return to WAIT.
// - Capture:
//   - Each audio_valid_in writes the capture bank at wr_ptr.
//   - When wr_ptr reaches FRAME_LEN-1 and the other bank is free: mark full, swap banks, wr_ptr=0.
//   - When the other bank is still streaming/pending: set overrun, drop the completed frame, wr_ptr=0, keep the same bank.
//   - Partial frames are never sent.
// - Latency: with the FSM in WAIT, fft_tvalid rises 2 cycles after the cycle capturing the last sample (1-cycle synchronous RAM read + output register).
//   - Capture during CFG is allowed; the frame waits in the bank.
// - A sample arriving in the same cycle as the stream-side bank release is captured normally; the release wins for the swap decision in that cycle.
// - Rx path:
//   - fft_out_tready follows the bin output stage's ready.
//   - bin_idx increments on each bin handshake and returns to 0 after bin_last.
//   - bin_last=fft_out_tlast.
//   - If fft_out_tlast arrives with bin_idx!=FRAME_LEN-1: set tlast_err; bin_idx still returns to 0.
// CONFIGURATION
// - FFT_MAG_EN defined:
//   - bin_data = {15'b0, |re|+|im|} (17-bit unsigned, |-32768|=32768).
//   - Registered one-entry output stage: fft_out_tready = !bin_valid | bin_ready.
//   - bin_valid one cycle after the core handshake.
// - FFT_MAG_EN undefined:
//   - bin_data = fft_out_tdata, passed combinationally.
//   - bin_valid = fft_out_tvalid, fft_out_tready = bin_ready; zero latency.
// TESTING
// - Reset, cfg_tready=1 on cycle 3 -> exactly one cfg handshake, cfg_tdata=16'h0001, FSM in WAIT.
// - 2048 strobes of audio_in=8'hFF, fft_tready=1 -> 2048 beats, tdata=32'h0000FF00, tlast only on beat 2047, frame_cnt=1.
// - fft_tready toggled every cycle during stream -> no beat lost or duplicated; tdata stable while stalled; 2048 beats total.
// - fft_tready=0 held while 2 more frames (8'h0F, 8'h8F) are captured -> overrun=1; 8'h0F frame sent; 8'h8F frame dropped.
// - Core output 2048 beats with tlast on beat 2047, bin_ready toggled -> bin_idx 0..2047, bin_last at 2047, tlast_err=0.
//   - Early tlast at beat 100 -> tlast_err=1, next bin_idx=0.
// - FFT_MAG_EN, out tdata={16'h8000,16'h0003} -> bin_data=32'd32771 one cycle later.
//   - Assert rst_in mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the xfft_1 core: ping-pong sample capture, one-shot config, frame streaming, bin indexing.
// Optional macro FFT_MAG_EN: registered |re|+|im| output stage instead of the raw bin pass-through.
module fft_frame_ctrl #(
  parameter int          FRAME_LEN = 2048,
  parameter int          SAMPLE_W  = 8,
  parameter logic [15:0] CFG_WORD  = 16'h0001,
  localparam int         IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [SAMPLE_W-1:0] audio_in,
  input  logic              audio_valid_in,
  output logic [15:0]       cfg_tdata,
  output logic              cfg_tvalid,
  input  logic              cfg_tready,
  output logic [31:0]       fft_tdata,
  output logic              fft_tvalid,
  output logic              fft_tlast,
  input  logic              fft_tready,
  input  logic [31:0]       fft_out_tdata,
  input  logic              fft_out_tvalid,
  input  logic              fft_out_tlast,
  output logic              fft_out_tready,
  output logic [31:0]       bin_data,
  output logic [IDX_W-1:0]  bin_idx,
  output logic              bin_valid,
  output logic              bin_last,
  input  logic              bin_ready,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  output logic              tlast_err,
  output logic [1:0]        tx_state
);

  // Handshake rule on every stream port: a beat transfers in a cycle where valid & ready are
  // both high; a source holding valid keeps its data (and last) stable until that cycle.

  typedef enum logic [1:0] {
    S_CFG    = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } tx_state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  tx_state_t            state_q, state_d;
  logic                 start, load, beat_hs, frame_done;
  logic [IDX_W:0]       rd_addr;
  logic [IDX_W-1:0]     rd_ptr_q;
  logic                 rd_bank_q;
  logic [SAMPLE_W-1:0]  rd_q;
  logic [SAMPLE_W-1:0]  mem [2*FRAME_LEN];

  logic                 cap_bank_q;
  logic [IDX_W-1:0]     wr_ptr_q;
  logic [1:0]           bank_full_q, bank_full_d;
  logic                 cap_last, other_free;

  assign cfg_tdata  = CFG_WORD;
  assign tx_state   = state_q;
  assign fft_tdata  = {16'h0000, rd_q, {(16-SAMPLE_W){1'b0}}};
  assign beat_hs    = fft_tvalid && fft_tready;
  assign frame_done = (state_q == S_STREAM) && beat_hs && fft_tlast;

  // ---------------- transmit FSM ----------------
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    load    = 1'b0;
    rd_addr = {rd_bank_q, rd_ptr_q};
    case (state_q)
      S_CFG: begin
        if (cfg_tvalid && cfg_tready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // At most one bank is ever pending, so bank_full_q[1] names it.
        if (|bank_full_q) begin
          state_d = S_STREAM;
          start   = 1'b1;
          load    = 1'b1;
          rd_addr = {bank_full_q[1], {IDX_W{1'b0}}};
        end
      end
      S_STREAM: begin
        if (beat_hs) begin
          if (fft_tlast) state_d = S_WAIT;
          else           load    = 1'b1;
        end
      end
      default: state_d = S_CFG;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_CFG;
      cfg_tvalid <= 1'b0;
      fft_tvalid <= 1'b0;
      fft_tlast  <= 1'b0;
      rd_ptr_q   <= '0;
      rd_bank_q  <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      state_q    <= state_d;
      cfg_tvalid <= (state_d == S_CFG);
      if (start) begin
        rd_bank_q <= bank_full_q[1];
        rd_ptr_q  <= IDX_W'(1);
      end else if (load) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      if (load) begin
        fft_tvalid <= 1'b1;
        fft_tlast  <= !start && (rd_ptr_q == LAST_IDX);
      end else if (frame_done) begin
        fft_tvalid <= 1'b0;
        fft_tlast  <= 1'b0;
        frame_cnt  <= frame_cnt + 16'd1;
      end
    end
  end

  // Sample RAM: capture writes one bank while the stream side reads the other.
  always_ff @(posedge clk_in) begin
    if (audio_valid_in) mem[{cap_bank_q, wr_ptr_q}] <= audio_in;
    if (load)           rd_q <= mem[rd_addr];
  end

  // ---------------- capture side ----------------
  assign cap_last   = audio_valid_in && (wr_ptr_q == LAST_IDX);
  // A release in the same cycle frees the other bank for this swap decision.
  assign other_free = !bank_full_q[!cap_bank_q] || (frame_done && (rd_bank_q == !cap_bank_q));

  always_comb begin
    bank_full_d = bank_full_q;
    if (frame_done)             bank_full_d[rd_bank_q]  = 1'b0;
    if (cap_last && other_free) bank_full_d[cap_bank_q] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cap_bank_q  <= 1'b0;
      wr_ptr_q    <= '0;
      bank_full_q <= 2'b00;
      overrun     <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      if (audio_valid_in) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (cap_last) begin
        if (other_free) cap_bank_q <= !cap_bank_q;
        else            overrun    <= 1'b1;
      end
    end
  end

  // ---------------- receive side ----------------
`ifdef FFT_MAG_EN
  logic [16:0] re_ext, im_ext, re_abs, im_abs, mag;

  assign re_ext = {fft_out_tdata[15], fft_out_tdata[15:0]};
  assign im_ext = {fft_out_tdata[31], fft_out_tdata[31:16]};
  assign re_abs = re_ext[16] ? (17'd0 - re_ext) : re_ext;
  assign im_abs = im_ext[16] ? (17'd0 - im_ext) : im_ext;
  assign mag    = re_abs + im_abs;
  assign fft_out_tready = !bin_valid || bin_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bin_valid <= 1'b0;
      bin_last  <= 1'b0;
      bin_data  <= 32'd0;
    end else if (fft_out_tready) begin
      bin_valid <= fft_out_tvalid;
      if (fft_out_tvalid) begin
        bin_data <= {15'd0, mag};
        bin_last <= fft_out_tlast;
      end
    end
  end
`else
  assign bin_data       = fft_out_tdata;
  assign bin_valid      = fft_out_tvalid;
  assign bin_last       = fft_out_tlast;
  assign fft_out_tready = bin_ready;
`endif

  // bin_idx tracks the bin currently offered on bin_data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bin_idx   <= '0;
      tlast_err <= 1'b0;
    end else if (bin_valid && bin_ready) begin
      if (bin_last) begin
        bin_idx <= '0;
        if (bin_idx != LAST_IDX) tlast_err <= 1'b1;
      end else begin
        bin_idx <= bin_idx + 1'b1;
      end
    end
  end

endmodule
